// File: rtl/lutram_sfifo_ctrl_pkg.sv
// Shared constants and elaboration-time helpers for the LUTRAM FWFT FIFO controller.
package lutram_sfifo_ctrl_pkg;

   // Pointer carries one extra wrap bit above the RAM address.
   function automatic int unsigned ptr_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   function automatic int unsigned clog2_u(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // usedw counts the output register too, so AFULL_TH may reach D+1.
   function automatic bit thresholds_legal(input int unsigned addr_w,
                                           input int unsigned afull_th,
                                           input int unsigned aempty_th);
      return (afull_th <= depth_of(addr_w) + 1) && (aempty_th < afull_th);
   endfunction

endpackage

// File: rtl/lutram_fifo_ptr.sv
// Wrap-bit pointer counter with synchronous clear and increment.
module lutram_fifo_ptr
   import lutram_sfifo_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [ADDR_W:0] ptr_o
);

   localparam int unsigned PTR_W = ptr_width(ADDR_W);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/lutram_sfifo_ctrl.sv
// Single-clock FWFT FIFO controller driving an external LUTRAM (sync write, async read)
// with a registered head word, level flags and sticky overflow/underflow.
module lutram_sfifo_ctrl
   import lutram_sfifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned AFULL_TH  = 28,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              wen,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_en,
   output logic [DATA_W-1:0] q,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   usedw,
   output logic              overflow,
   output logic              underflow,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_wraddress,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_rdaddress,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int unsigned PTR_W = ptr_width(ADDR_W);
   localparam int unsigned DEPTH = depth_of(ADDR_W);

   if (!thresholds_legal(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
      $error("lutram_sfifo_ctrl: need AFULL_TH <= D+1 and AEMPTY_TH < AFULL_TH");
   end

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  ram_cnt;
   logic [PTR_W-1:0]  usedw_w;
   logic              ram_nonempty;
   logic              wr_accept;
   logic              load;

   logic [DATA_W-1:0] dout_q;
   logic [DATA_W-1:0] dout_d;
   logic              dout_valid_q;
   logic              dout_valid_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              udf_q;
   logic              udf_d;

   assign ram_cnt      = wr_ptr - rd_ptr;
   assign ram_nonempty = (ram_cnt != '0);
   assign full         = (ram_cnt == PTR_W'(DEPTH));

   assign wr_accept = wen & ~full & ~clr;
   // Loading only from a non-empty RAM keeps reads off the address being written this cycle.
   assign load      = ram_nonempty & (~dout_valid_q | rd_en) & ~clr;

   lutram_fifo_ptr #(
      .ADDR_W (ADDR_W)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (reset_n),
      .clr_i (clr),
      .inc_i (wr_accept),
      .ptr_o (wr_ptr)
   );

   lutram_fifo_ptr #(
      .ADDR_W (ADDR_W)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (reset_n),
      .clr_i (clr),
      .inc_i (load),
      .ptr_o (rd_ptr)
   );

   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      ovf_d        = ovf_q | (wen & full);
      udf_d        = udf_q | (rd_en & ~dout_valid_q);
      if (clr) begin
         dout_valid_d = 1'b0;
         ovf_d        = 1'b0;
         udf_d        = 1'b0;
      end else if (load) begin
         dout_d       = ram_q;
         dout_valid_d = 1'b1;
      end else if (rd_en && dout_valid_q) begin
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   assign usedw_w = ram_cnt + PTR_W'(dout_valid_q);

   assign q            = dout_q;
   assign empty        = ~dout_valid_q;
   assign usedw        = usedw_w;
   assign almost_full  = (32'(usedw_w) >= AFULL_TH);
   assign almost_empty = (32'(usedw_w) <= AEMPTY_TH);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   assign ram_wren      = wr_accept;
   assign ram_wraddress = wr_ptr[ADDR_W-1:0];
   assign ram_data      = wdata;
   assign ram_rdaddress = rd_ptr[ADDR_W-1:0];

endmodule
